print_job_requester: RTL
========================

Name: print_job_requester

Overview:
- Client side of the three-way shared-printer arbitration interface. Holds per-client print jobs (B, E, Y) in small queues.
- Drives the request lines rb/re/ry toward the printer arbiter and consumes the arbiter's 2-bit grant code (0 none, 1 B, 2 E, 3 Y).
- Holds each request for exactly the job's page count of granted cycles, then releases it so the arbiter rotates.
- Sits between the job-submission logic and the printer arbiter.

Parameters:
- DEPTH, 4, jobs per client queue (power of two, >=2)
- PAGE_W, 4, width of the page-count field
- STARVE_LIMIT, 64, wait-cycle threshold for the optional watchdog

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- push_valid  input  1  job submission strobe
- push_client  input  2  target client: 1=B, 2=E, 3=Y; 0 is invalid
- push_pages  input  PAGE_W  job length in pages (granted cycles)
- push_ready  output  1  job accepted when push_valid && push_ready
- push_err  output  1  one-cycle pulse on a rejected push (client 0 or pages 0)
- grant  input  2  arbiter grant code
- rb, re, ry  output  1 each  registered request lines
- done  output  3  per-client one-cycle job-complete pulse, bit0=B, bit1=E, bit2=Y
- busy  output  3  client state != IDLE
- level_b, level_e, level_y  output  clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset: queues empty, all levels 0, rb/re/ry=0, done=0, busy=0, push_err=0, every client FSM in IDLE. A reset mid-job discards all jobs without a done pulse.
- Queue accepts:
  - push_ready = push_valid-independent combinational "selected client queue not full"; it is 0 when push_client==0.
  - Acceptance is decided on full as registered. A push to a full queue is not accepted, even if that queue pops in the same cycle; no push_err in that case.
- Queue rejects: push_client==0 or push_pages==0 with push_valid=1 is dropped and pulses push_err on the next cycle.
- Queue ordering: FIFO per client. Read and write pointers wrap modulo DEPTH. A simultaneous push and pop on one queue keeps level unchanged.
- Per-client FSM, each client with id i:
  - IDLE (req=0): at an edge with queue non-empty, load cnt<=head pages, req<=1, go WAIT.
  - WAIT (req=1): at an edge with grant==i, go PRINT and decrement cnt. If cnt was 1, act as the PRINT completion case instead.
  - PRINT (req=1): at each edge with grant==i, cnt<=cnt-1.
    - At the edge where cnt==1 and grant==i: pop the head, done[i]<=1 for one cycle, req<=0, go IDLE.
    - If grant!=i while in PRINT (grant lost), hold cnt, keep req=1 and return to WAIT.
- Latency:
  - A push accepted at edge E0 gives req high after E1.
  - A job of N pages consumes exactly N edges with grant==i.
  - Between back-to-back jobs of one client, req is low for exactly one cycle, which guarantees the arbiter observes the release.
- The three clients are fully independent. A grant code matching no waiting client is ignored.

Optional Feature:
- Macro STARVE_WATCHDOG_EN.
- Defined:
  - Adds output starve[2:0] and a per-client wait counter.
  - The counter increments each cycle the client is in WAIT with grant!=i, saturating at STARVE_LIMIT, and clears on entering PRINT or IDLE.
  - starve[i] sets sticky when the counter reaches STARVE_LIMIT and clears only on rst.
- Undefined: the port and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then push B with 3 pages: rb rises 1 cycle after the push. Grant=1 held for 3 cycles gives done[0] after the 3rd granted edge, rb low the next cycle, level_b 1->0.
- Push E=2 and Y=2 in consecutive cycles, with the arbiter model granting E then Y: re drops after 2 granted cycles, then ry drops after 2, done[1] then done[2].
- Fill B queue with DEPTH=4 jobs: the 5th push sees push_ready=0, level_b stays 4. Pop one, then the push is accepted.
- push_client=0 or push_pages=0: push_err pulse, no level change, no request.
- B in PRINT with cnt=2, grant drops to 0 for 3 cycles: rb stays 1, cnt holds. Grant returns: 2 more granted cycles, then done[0].
- Assert rst during a Y job mid-PRINT: ry=0 and level_y=0 immediately, no done pulse. With STARVE_WATCHDOG_EN and STARVE_LIMIT=8, withhold grant 8 cycles and starve[0] sets.

Source files
------------

// File: rtl/print_job_requester.sv
// print_job_requester: per-client (B/E/Y) print-job queues driving rb/re/ry toward the printer arbiter.
// Optional feature macro STARVE_WATCHDOG_EN adds a sticky per-client starvation flag output.
module print_job_requester #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned PAGE_W       = 4,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [1:0]             push_client,
  input  logic [PAGE_W-1:0]      push_pages,
  output logic                   push_ready,
  output logic                   push_err,
  input  logic [1:0]             grant,
  output logic                   rb,
  output logic                   re,
  output logic                   ry,
  output logic [2:0]             done,
  output logic [2:0]             busy,
  output logic [$clog2(DEPTH):0] level_b,
  output logic [$clog2(DEPTH):0] level_e,
  output logic [$clog2(DEPTH):0] level_y
`ifdef STARVE_WATCHDOG_EN
  ,
  output logic [2:0]             starve
`endif
);

  localparam int unsigned NC = 3;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRINT} state_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT == 0) begin : g_bad_param
    $error("print_job_requester: DEPTH must be a power of two >= 2 and STARVE_LIMIT nonzero");
  end

  logic [PAGE_W-1:0] mem     [NC][DEPTH];
  logic [AW-1:0]     wr_ptr  [NC];
  logic [AW-1:0]     rd_ptr  [NC];
  logic [LW-1:0]     level   [NC];
  state_t            state   [NC];
  state_t            state_nxt [NC];
  logic [PAGE_W-1:0] cnt     [NC];
  logic [PAGE_W-1:0] cnt_nxt [NC];

  logic [NC-1:0] full_c;
  logic [NC-1:0] push_c;
  logic [NC-1:0] pop_c;
  logic [3:0]    ready_vec_c;
  logic [NC-1:0] req_q;
  logic [NC-1:0] done_q;
  logic          push_err_q;

  // Acceptance uses registered fullness, so a same-cycle pop never frees a slot for the push.
  always_comb begin
    full_c = '0;
    push_c = '0;
    for (int c = 0; c < NC; c++) begin
      full_c[c] = (level[c] == LW'(DEPTH));
      push_c[c] = push_valid && (push_client == 2'(c + 1)) &&
                  (push_pages != '0) && !full_c[c];
    end
  end

  assign ready_vec_c = {~full_c, 1'b0};
  assign push_ready  = ready_vec_c[push_client];

  // Per-client next state; WAIT and PRINT share the grant handling.
  always_comb begin
    pop_c = '0;
    for (int c = 0; c < NC; c++) begin
      state_nxt[c] = state[c];
      cnt_nxt[c]   = cnt[c];
      case (state[c])
        S_IDLE: begin
          if (level[c] != '0) begin
            cnt_nxt[c]   = mem[c][rd_ptr[c]];
            state_nxt[c] = S_WAIT;
          end
        end
        S_WAIT, S_PRINT: begin
          if (grant == 2'(c + 1)) begin
            if (cnt[c] == PAGE_W'(1)) begin
              pop_c[c]     = 1'b1;
              state_nxt[c] = S_IDLE;
            end else begin
              cnt_nxt[c]   = cnt[c] - PAGE_W'(1);
              state_nxt[c] = S_PRINT;
            end
          end else begin
            state_nxt[c] = S_WAIT;
          end
        end
        default: state_nxt[c] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin : fsm_reg
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        state[c] <= S_IDLE;
        cnt[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        state[c] <= state_nxt[c];
        cnt[c]   <= cnt_nxt[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : queue_reg
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        level[c]  <= '0;
      end
      req_q      <= '0;
      done_q     <= '0;
      push_err_q <= 1'b0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (push_c[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
        if (pop_c[c])  rd_ptr[c] <= rd_ptr[c] + AW'(1);
        level[c] <= level[c] + LW'(push_c[c]) - LW'(pop_c[c]);
        req_q[c] <= (state_nxt[c] != S_IDLE);
      end
      done_q     <= pop_c;
      push_err_q <= push_valid && ((push_client == 2'd0) || (push_pages == '0));
    end
  end

  always_ff @(posedge clk) begin : mem_wr
    for (int c = 0; c < NC; c++) begin
      if (push_c[c]) mem[c][wr_ptr[c]] <= push_pages;
    end
  end

  assign rb       = req_q[0];
  assign re       = req_q[1];
  assign ry       = req_q[2];
  assign busy     = req_q;
  assign done     = done_q;
  assign push_err = push_err_q;
  assign level_b  = level[0];
  assign level_e  = level[1];
  assign level_y  = level[2];

`ifdef STARVE_WATCHDOG_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] wait_cnt [NC];
  logic [SW-1:0] wait_nxt [NC];
  logic [NC-1:0] starve_q;

  // Counts only cycles spent waiting without our grant; any other state clears it.
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      wait_nxt[c] = '0;
      if (state[c] == S_WAIT && grant != 2'(c + 1)) begin
        wait_nxt[c] = (wait_cnt[c] == SW'(STARVE_LIMIT)) ? wait_cnt[c] : wait_cnt[c] + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : starve_reg
    if (rst) begin
      for (int c = 0; c < NC; c++) wait_cnt[c] <= '0;
      starve_q <= '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        wait_cnt[c] <= wait_nxt[c];
        starve_q[c] <= starve_q[c] | (wait_nxt[c] == SW'(STARVE_LIMIT));
      end
    end
  end

  assign starve = starve_q;
`endif

endmodule
